// File: rtl/result_drain.sv
// -----------------------------------------------------------------------------
// result_drain
//   Transmit side of the accelerator's AXI-Stream datapath. Collects one N x N
//   result tile from the systolic array (N rows, in order) into a local
//   register buffer, then streams it out as N*N beats on an AXIS master with
//   tlast on the final beat.
//
//   Build option: DRAIN_TRANSPOSE_EN
//     undefined : beats leave in row-major order (beat k = buf[k/N][k%N])
//     defined   : beats leave in column-major order (beat k = buf[k%N][k/N]),
//                 i.e. the transposed tile; count, tlast and timing unchanged.
//
//   Ports
//     i_clk          clock, all logic on posedge
//     i_rst_n        synchronous active-low reset
//     arr_C_valid    array presents a result row on arr_C_data
//     arr_C_data     result row, element c at [c*DATA_W +: DATA_W]
//     arr_C_ready    drain accepts a row (IDLE or CAPTURE), registered
//     m_axis_tdata   streamed result element, registered
//     m_axis_tvalid  beat valid, registered
//     m_axis_tready  downstream accepts beat
//     m_axis_tlast   final beat of the tile, registered
//     o_done         one-cycle pulse after the last beat is accepted
//     o_overrun      sticky: a row was offered while arr_C_ready was low
// -----------------------------------------------------------------------------
module result_drain #(
   parameter int N      = 4,
   parameter int DATA_W = 32
) (
   input  logic                  i_clk,
   input  logic                  i_rst_n,
   input  logic                  arr_C_valid,
   input  logic [N*DATA_W-1:0]   arr_C_data,
   output logic                  arr_C_ready,
   output logic [DATA_W-1:0]     m_axis_tdata,
   output logic                  m_axis_tvalid,
   input  logic                  m_axis_tready,
   output logic                  m_axis_tlast,
   output logic                  o_done,
   output logic                  o_overrun
);

   localparam int CW = $clog2(N*N+1);
   localparam int BW = N*N*DATA_W;
   localparam int SW = (BW > 1) ? $clog2(BW) : 1;
   localparam logic [CW-1:0] ROW_LAST  = CW'(N-1);
   localparam logic [CW-1:0] BEAT_LAST = CW'(N*N-1);
   localparam logic [CW-1:0] CNT_ONE   = CW'(1);
   localparam logic [CW-1:0] CNT_ZERO  = CW'(0);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      CAPTURE = 2'd1,
      STREAM  = 2'd2
   } state_t;

   state_t            state_r;
   logic [CW-1:0]     row_cnt_r;
   logic [CW-1:0]     beat_idx_r;
   logic [BW-1:0]     buf_r;       // flat tile, element (r,c) at (r*N+c)*DATA_W
   logic              row_wr_s;
   logic [CW-1:0]     beat_nxt_s;
   logic [DATA_W-1:0] first_elem_s;

   // Bit offset of row idx inside the flat buffer.
   function automatic logic [SW-1:0] row_off(input logic [CW-1:0] idx);
      return SW'(int'(idx) * N * DATA_W);
   endfunction

   // Bit offset of the element emitted as beat idx.
   function automatic logic [SW-1:0] beat_off(input logic [CW-1:0] idx);
      int k;
      int e;
      k = int'(idx);
`ifdef DRAIN_TRANSPOSE_EN
      e = (k % N) * N + (k / N);
`else
      e = k;
`endif
      return SW'(e * DATA_W);
   endfunction

   assign row_wr_s   = arr_C_valid & arr_C_ready;
   assign beat_nxt_s = beat_idx_r + CNT_ONE;
   // Beat 0 is element (0,0) in either order; with N==1 it is still on the
   // input bus in the cycle the FSM enters STREAM.
   assign first_elem_s = (N == 1) ? arr_C_data[DATA_W-1:0] : buf_r[DATA_W-1:0];

   // Tile buffer: written one row at a time, contents are don't-care after reset.
   always_ff @(posedge i_clk) begin
      if (i_rst_n && row_wr_s) begin
         buf_r[row_off(row_cnt_r) +: N*DATA_W] <= arr_C_data;
      end
   end

   // Capture/stream FSM with all outputs registered.
   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         state_r       <= IDLE;
         row_cnt_r     <= CNT_ZERO;
         beat_idx_r    <= CNT_ZERO;
         arr_C_ready   <= 1'b1;
         m_axis_tvalid <= 1'b0;
         m_axis_tlast  <= 1'b0;
         m_axis_tdata  <= {DATA_W{1'b0}};
         o_done        <= 1'b0;
         o_overrun     <= 1'b0;
      end else begin
         o_done <= 1'b0;
         if (arr_C_valid && !arr_C_ready) begin
            o_overrun <= 1'b1;
         end
         case (state_r)
            IDLE, CAPTURE: begin
               if (arr_C_valid) begin
                  row_cnt_r <= row_cnt_r + CNT_ONE;
                  if (row_cnt_r == ROW_LAST) begin
                     state_r       <= STREAM;
                     arr_C_ready   <= 1'b0;
                     m_axis_tvalid <= 1'b1;
                     m_axis_tdata  <= first_elem_s;
                     m_axis_tlast  <= (BEAT_LAST == CNT_ZERO);
                  end else begin
                     state_r <= CAPTURE;
                  end
               end
            end
            STREAM: begin
               if (m_axis_tready) begin
                  if (beat_idx_r == BEAT_LAST) begin
                     state_r       <= IDLE;
                     o_done        <= 1'b1;
                     beat_idx_r    <= CNT_ZERO;
                     row_cnt_r     <= CNT_ZERO;
                     arr_C_ready   <= 1'b1;
                     m_axis_tvalid <= 1'b0;
                     m_axis_tlast  <= 1'b0;
                  end else begin
                     beat_idx_r    <= beat_nxt_s;
                     m_axis_tdata  <= buf_r[beat_off(beat_nxt_s) +: DATA_W];
                     m_axis_tlast  <= (beat_nxt_s == BEAT_LAST);
                  end
               end
            end
            default: begin
               state_r       <= IDLE;
               row_cnt_r     <= CNT_ZERO;
               beat_idx_r    <= CNT_ZERO;
               arr_C_ready   <= 1'b1;
               m_axis_tvalid <= 1'b0;
               m_axis_tlast  <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_result_drain.sv
// -----------------------------------------------------------------------------
// tb_result_drain
//   Scoreboard bench for result_drain (N=4, DATA_W=32). Stimulus pushes the
//   expected beats of each tile into exp_q; an independent monitor pops and
//   compares every accepted beat, checks hold-stability under backpressure
//   and the o_done pulse. Element value = base + 16*r + c.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_result_drain;

   localparam int N      = 4;
   localparam int DATA_W = 32;

   logic                i_clk;
   logic                i_rst_n;
   logic                arr_C_valid;
   logic [N*DATA_W-1:0] arr_C_data;
   logic                arr_C_ready;
   logic [DATA_W-1:0]   m_axis_tdata;
   logic                m_axis_tvalid;
   logic                m_axis_tready;
   logic                m_axis_tlast;
   logic                o_done;
   logic                o_overrun;

   int checks = 0;
   int errors = 0;

   logic [DATA_W:0] exp_q[$];   // {last, data}
   logic            exp_done   = 1'b0;
   logic            stall_prev = 1'b0;
   logic [DATA_W-1:0] held_data = 32'd0;
   logic            held_last  = 1'b0;
   logic            bp_en      = 1'b0;

   result_drain #(.N(N), .DATA_W(DATA_W)) dut (
      .i_clk         (i_clk),
      .i_rst_n       (i_rst_n),
      .arr_C_valid   (arr_C_valid),
      .arr_C_data    (arr_C_data),
      .arr_C_ready   (arr_C_ready),
      .m_axis_tdata  (m_axis_tdata),
      .m_axis_tvalid (m_axis_tvalid),
      .m_axis_tready (m_axis_tready),
      .m_axis_tlast  (m_axis_tlast),
      .o_done        (o_done),
      .o_overrun     (o_overrun)
   );

   // Clock generation.
   initial begin
      i_clk = 1'b0;
      forever #5 i_clk = ~i_clk;
   end

   // Global time bound.
   initial begin
      #200000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1, "timeout");
   end

   // tready driver: constant 1, or the pattern 1,0,0,1 repeating.
   initial begin
      logic [3:0] pat;
      int ph;
      pat = 4'b1001;
      ph  = 0;
      m_axis_tready = 1'b1;
      forever begin
         @(posedge i_clk);
         #1;
         if (bp_en) begin
            m_axis_tready = pat[3 - ph];
            ph = (ph + 1) % 4;
         end else begin
            m_axis_tready = 1'b1;
            ph = 0;
         end
      end
   end

   task automatic chk(input string name, input logic [DATA_W-1:0] act, input logic [DATA_W-1:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, req);
      end
   endtask

   // Monitor / scoreboard: samples on the falling edge.
   always @(negedge i_clk) begin
      logic [DATA_W:0] e;
      if (!i_rst_n) begin
         exp_done   = 1'b0;
         stall_prev = 1'b0;
      end else begin
         chk("o_done", {31'd0, o_done}, {31'd0, exp_done});
         exp_done = 1'b0;
         if (stall_prev) begin
            chk("hold_tvalid", {31'd0, m_axis_tvalid}, 32'd1);
            chk("hold_tdata", m_axis_tdata, held_data);
            chk("hold_tlast", {31'd0, m_axis_tlast}, {31'd0, held_last});
         end
         if (m_axis_tvalid && m_axis_tready) begin
            if (exp_q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_beat: got 0x%08h expected no beat", m_axis_tdata);
            end else begin
               e = exp_q.pop_front();
               chk("beat_data", m_axis_tdata, e[DATA_W-1:0]);
               chk("beat_last", {31'd0, m_axis_tlast}, {31'd0, e[DATA_W]});
               if (e[DATA_W]) exp_done = 1'b1;
            end
         end
         stall_prev = m_axis_tvalid && !m_axis_tready;
         held_data  = m_axis_tdata;
         held_last  = m_axis_tlast;
      end
   end

   task automatic step();
      @(posedge i_clk);
      #1;
   endtask

   task automatic push_tile(input logic [DATA_W-1:0] base);
      int r;
      int c;
      for (int k = 0; k < N*N; k++) begin
`ifdef DRAIN_TRANSPOSE_EN
         r = k % N;
         c = k / N;
`else
         r = k / N;
         c = k % N;
`endif
         exp_q.push_back({(k == N*N-1) ? 1'b1 : 1'b0, base + DATA_W'(16*r + c)});
      end
   endtask

   task automatic send_row(input int r, input logic [DATA_W-1:0] base);
      for (int c = 0; c < N; c++) arr_C_data[c*DATA_W +: DATA_W] = base + DATA_W'(16*r + c);
      arr_C_valid = 1'b1;
      step();
      arr_C_valid = 1'b0;
   endtask

   // Feed a full tile back-to-back and check tvalid latency around row N-1.
   task automatic feed_tile(input logic [DATA_W-1:0] base);
      push_tile(base);
      for (int r = 0; r < N; r++) begin
         if (r == N-1) begin
            @(negedge i_clk);
            chk("tvalid_before_last_row", {31'd0, m_axis_tvalid}, 32'd0);
         end
         send_row(r, base);
      end
      @(negedge i_clk);
      chk("tvalid_after_last_row", {31'd0, m_axis_tvalid}, 32'd1);
   endtask

   task automatic wait_drain();
      int cyc;
      cyc = 0;
      while ((exp_q.size() != 0 || m_axis_tvalid) && cyc < 500) begin
         @(negedge i_clk);
         cyc++;
      end
      checks++;
      if (cyc >= 500) begin
         errors++;
         $display("FAIL drain_timeout: %0d beats still pending, expected 0", exp_q.size());
      end
      repeat (2) @(negedge i_clk);
   endtask

   initial begin
      logic [DATA_W-1:0] gap_pat_base;
      logic [6:0] gaps;
      int row;
      i_rst_n     = 1'b0;
      arr_C_valid = 1'b0;
      arr_C_data  = '0;

      // 1: reset state
      repeat (3) step();
      @(negedge i_clk);
      chk("rst_arr_C_ready", {31'd0, arr_C_ready}, 32'd1);
      chk("rst_tvalid", {31'd0, m_axis_tvalid}, 32'd0);
      chk("rst_tlast", {31'd0, m_axis_tlast}, 32'd0);
      chk("rst_done", {31'd0, o_done}, 32'd0);
      chk("rst_overrun", {31'd0, o_overrun}, 32'd0);
      i_rst_n = 1'b1;
      step();

      // 2: back-to-back tile, tready=1, exact drain timing
      feed_tile(32'h0000_0000);
      repeat (15) @(negedge i_clk);
      chk("beat15_tvalid", {31'd0, m_axis_tvalid}, 32'd1);
      chk("beat15_tlast", {31'd0, m_axis_tlast}, 32'd1);
      @(negedge i_clk);
      chk("ready_return", {31'd0, arr_C_ready}, 32'd1);
      chk("tvalid_drop", {31'd0, m_axis_tvalid}, 32'd0);
      wait_drain();

      // 3 + 4: backpressure, and an overrun row offered during STREAM
      bp_en = 1'b1;
      step();
      feed_tile(32'h0000_0100);
      arr_C_data  = {4{32'hDEAD_BEEF}};
      arr_C_valid = 1'b1;
      step();
      arr_C_valid = 1'b0;
      @(negedge i_clk);
      chk("overrun_set", {31'd0, o_overrun}, 32'd1);
      wait_drain();
      chk("overrun_sticky", {31'd0, o_overrun}, 32'd1);
      bp_en = 1'b0;
      step();

      // 5: reset after row 2 aborts the tile
      for (int r = 0; r < 3; r++) send_row(r, 32'h0000_0200);
      i_rst_n = 1'b0;
      step();
      @(negedge i_clk);
      chk("abort_ready", {31'd0, arr_C_ready}, 32'd1);
      chk("abort_tvalid", {31'd0, m_axis_tvalid}, 32'd0);
      chk("abort_overrun_clr", {31'd0, o_overrun}, 32'd0);
      i_rst_n = 1'b1;
      repeat (4) step();
      @(negedge i_clk);
      chk("abort_no_beats", {31'd0, m_axis_tvalid}, 32'd0);
      feed_tile(32'h0000_0300);
      wait_drain();

      // 6: rows with idle gaps, valid pattern 1,0,1,0,0,1,1
      gap_pat_base = 32'h0000_0400;
      gaps = 7'b1010011;
      row  = 0;
      push_tile(gap_pat_base);
      for (int i = 6; i >= 0; i--) begin
         if (gaps[i]) begin
            send_row(row, gap_pat_base);
            row++;
         end else begin
            step();
         end
      end
      @(negedge i_clk);
      chk("gap_tvalid", {31'd0, m_axis_tvalid}, 32'd1);
      wait_drain();
      chk("final_overrun_clear", {31'd0, o_overrun}, 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
